// File: rtl/fetch.sv
// fetch -- instruction fetch front end.
//
// Issues word-aligned fetch requests to instruction memory, tracks the
// requests still outstanding, pairs each returning word with its address
// and queues the result in a small FIFO towards decode. A redirect flushes
// everything queued or in flight and restarts fetch at a new address; the
// responses still owed for flushed requests are counted and silently dropped.
//
// Parameters
//   RESET_PC  first fetch address after reset (word aligned)
//   DEPTH     instruction buffer entries and cap on requests in flight (2..8)
//
// Ports
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   imem_req_valid_o/ready_i, addr_o   fetch request handshake and address
//   imem_rsp_valid_i, rsp_data_i       in-order response from memory
//   redirect_i, redirect_pc_i          flush and restart at a new address
//   valid_o, ready_i                   handshake towards decode
//   instruction_o, pc_o                buffer head word and its address
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o
);

  localparam int          PW   = $clog2(DEPTH);
  localparam int          CW   = $clog2(DEPTH + 1);
  // Stale responses can pile up across repeated redirects while new
  // requests keep issuing, so the drop counter is deliberately wide.
  localparam int          DW   = 16;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [CW-1:0] count_reg, count_next;
  logic [CW-1:0] inflight_reg, inflight_next;
  logic [DW-1:0] drop_reg, drop_next;
  logic [PW-1:0] buf_rd_reg, buf_rd_next, buf_wr_reg, buf_wr_next;
  logic [PW-1:0] pq_rd_reg, pq_rd_next, pq_wr_reg, pq_wr_next;

  // Instruction buffer (word + address) and the in-order queue of
  // addresses whose responses are still expected.
  logic [31:0] buf_instr [DEPTH];
  logic [31:0] buf_pc    [DEPTH];
  logic [31:0] pq_pc     [DEPTH];

  logic        accept;
  logic        rsp_keep;
  logic        pop;
  logic [CW:0] occupancy;

  always_comb begin
    occupancy = {1'b0, count_reg} + {1'b0, inflight_reg};
    // Gating with rst_ni keeps the request low while reset is held; the
    // first request then issues in the first cycle after release.
    imem_req_valid_o = rst_ni && !redirect_i && (occupancy < (CW+1)'(DEPTH));
    imem_addr_o      = fetch_pc_reg;
    accept           = imem_req_valid_o && imem_req_ready_i;
    valid_o          = (count_reg != '0);
    pop              = valid_o && ready_i;
    instruction_o    = buf_instr[buf_rd_reg];
    pc_o             = buf_pc[buf_rd_reg];
    // A response is only written when nothing stale is owed and no flush
    // is happening in the same cycle.
    rsp_keep         = imem_rsp_valid_i && (drop_reg == '0) && !redirect_i &&
                       (inflight_reg != '0);
  end

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    count_next    = count_reg;
    inflight_next = inflight_reg;
    drop_next     = drop_reg;
    buf_rd_next   = buf_rd_reg;
    buf_wr_next   = buf_wr_reg;
    pq_rd_next    = pq_rd_reg;
    pq_wr_next    = pq_wr_reg;
    if (redirect_i) begin
      fetch_pc_next = redirect_pc_i & ~32'h0000_0003;
      count_next    = '0;
      inflight_next = '0;
      buf_rd_next   = '0;
      buf_wr_next   = '0;
      pq_rd_next    = '0;
      pq_wr_next    = '0;
      // Everything owed becomes stale, minus a response that lands right
      // now (it is discarded and therefore no longer owed).
      drop_next = drop_reg + DW'(inflight_reg) -
                  DW'(imem_rsp_valid_i && ((drop_reg != '0) || (inflight_reg != '0)));
    end else begin
      if (accept) begin
        fetch_pc_next = fetch_pc_reg + 32'd4;
        pq_wr_next    = inc(pq_wr_reg);
      end
      if (imem_rsp_valid_i && (drop_reg != '0)) begin
        drop_next = drop_reg - 1'b1;
      end
      if (rsp_keep) begin
        pq_rd_next  = inc(pq_rd_reg);
        buf_wr_next = inc(buf_wr_reg);
      end
      if (pop) begin
        buf_rd_next = inc(buf_rd_reg);
      end
      inflight_next = inflight_reg + CW'(accept) - CW'(rsp_keep);
      count_next    = count_reg + CW'(rsp_keep) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_reg <= RESET_PC;
      count_reg    <= '0;
      inflight_reg <= '0;
      drop_reg     <= '0;
      buf_rd_reg   <= '0;
      buf_wr_reg   <= '0;
      pq_rd_reg    <= '0;
      pq_wr_reg    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_instr[i] <= NOP;
        buf_pc[i]    <= RESET_PC;
        pq_pc[i]     <= '0;
      end
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      count_reg    <= count_next;
      inflight_reg <= inflight_next;
      drop_reg     <= drop_next;
      buf_rd_reg   <= buf_rd_next;
      buf_wr_reg   <= buf_wr_next;
      pq_rd_reg    <= pq_rd_next;
      pq_wr_reg    <= pq_wr_next;
      if (accept) begin
        pq_pc[pq_wr_reg] <= fetch_pc_reg;
      end
      if (rsp_keep) begin
        buf_instr[buf_wr_reg] <= imem_rsp_data_i;
        buf_pc[buf_wr_reg]    <= pq_pc[pq_rd_reg];
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
// tb_fetch -- self-checking bench for fetch.
//
// An in-order memory model with programmable latency answers requests with
// data = address ^ KEY. Accepted requests are tagged with the current
// redirect epoch; responses from the current epoch are pushed to a
// scoreboard queue and compared when decode pops them. Directed phases
// cover reset, streaming, decode stall, redirects and address wrap.
module tb_fetch;

  localparam int          DEPTH = 3;
  localparam logic [31:0] KEY   = 32'hC0DE_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk_i;
  logic        rst_ni;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;

  // Second instance used only for the address wrap-around check.
  logic        req_valid2, req_ready2, rsp_valid2, redirect2, valid2, ready2;
  logic [31:0] addr2, rsp_data2, redirect_pc2, instr2, pc2;

  fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_addr_o(imem_addr_o),
    .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .instruction_o(instruction_o), .pc_o(pc_o)
  );

  fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut2 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .imem_req_valid_o(req_valid2), .imem_req_ready_i(req_ready2),
    .imem_addr_o(addr2),
    .imem_rsp_valid_i(rsp_valid2), .imem_rsp_data_i(rsp_data2),
    .redirect_i(redirect2), .redirect_pc_i(redirect_pc2),
    .valid_o(valid2), .ready_i(ready2),
    .instruction_o(instr2), .pc_o(pc2)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  req_t mq[$];
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   lat   = 1;
  int   epoch = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Memory response driver: answers the oldest request once it is due.
  initial begin
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    forever begin
      @(posedge clk_i);
      cyc++;
      #1;
      if (!rst_ni) begin
        mq.delete();
        imem_rsp_valid_i = 1'b0;
      end else if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = mq[0].addr ^ KEY;
      end else begin
        imem_rsp_valid_i = 1'b0;
      end
    end
  end

  // Monitor: scoreboard pops on delivery, pushes on kept responses.
  initial begin
    forever begin
      sample();
      if (!rst_ni) begin
        exp_q.delete();
        epoch++;
      end else begin
        check("no_ovf", 32'(dut.count_reg <= DEPTH), 32'd1);
        if (valid_o && ready_i) begin
          check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            $display("deliver pc=%h instr=%h", pc_o, instruction_o);
            check("sb_pc", pc_o, e.pc);
            check("sb_instr", instruction_o, e.instr);
          end
        end
        if (imem_rsp_valid_i && mq.size() > 0) begin
          req_t r;
          r = mq.pop_front();
          if (!redirect_i && r.epoch == epoch) begin
            exp_q.push_back('{pc: r.addr, instr: r.addr ^ KEY});
          end
        end
        if (redirect_i) begin
          exp_q.delete();
          epoch++;
        end
        if (imem_req_valid_o && imem_req_ready_i) begin
          mq.push_back('{addr: imem_addr_o, epoch: epoch, due: cyc + lat});
        end
      end
    end
  end

  initial begin
    int acc;
    rst_ni = 1'b1;
    ready_i = 1'b1;
    imem_req_ready_i = 1'b1;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    req_ready2 = 1'b1;
    rsp_valid2 = 1'b0;
    rsp_data2 = '0;
    redirect2 = 1'b0;
    redirect_pc2 = '0;
    ready2 = 1'b1;
    #1 rst_ni = 1'b0;
    #1;
    check("rst_valid", valid_o, 1'b0);
    check("rst_req_valid", imem_req_valid_o, 1'b0);
    check("rst_instr", instruction_o, NOP);
    check("rst_pc", pc_o, 32'h0);
    check("rst_pc_wrapdut", pc2, 32'hFFFF_FFF8);

    // Streaming from reset: memory ready, latency 1, decode ready.
    repeat (2) next_cycle();
    rst_ni = 1'b1;
    for (int k = 0; k < 6; k++) begin
      sample();
      check("p1_req_valid", imem_req_valid_o, 1'b1);
      check("p1_addr", imem_addr_o, 32'(4 * k));
      check("p1_valid", valid_o, 32'(k >= 2));
      if (k >= 2) check("p1_pc", pc_o, 32'(4 * (k - 2)));
      if (k < 3) check("p1_wrap_addr", addr2, 32'hFFFF_FFF8 + 32'(4 * k));
      next_cycle();
    end

    // Asynchronous reset with a non-empty buffer.
    #1;
    check("pre_rst_valid", valid_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    check("async_rst_valid", valid_o, 1'b0);
    check("async_rst_req", imem_req_valid_o, 1'b0);
    check("async_rst_pc", pc_o, 32'h0);
    ready_i = 1'b0;
    repeat (2) next_cycle();
    rst_ni = 1'b1;

    // Decode stalled for 10 cycles.
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      sample();
      if (k == 0) check("p2_first_addr", imem_addr_o, 32'h0);
      if (imem_req_valid_o && imem_req_ready_i) acc++;
      if (k >= 2) begin
        check("p2_hold_pc", pc_o, 32'h0);
        check("p2_hold_instr", instruction_o, KEY);
      end
      next_cycle();
    end
    check("p2_req_count", 32'(acc), 32'(DEPTH));
    sample();
    check("p2_stall_req", imem_req_valid_o, 1'b0);
    check("p2_valid", valid_o, 1'b1);
    check("p2_pc", pc_o, 32'h0);
    next_cycle();
    ready_i = 1'b1;
    sample();
    check("p2_rel_pc0", pc_o, 32'h0);
    next_cycle();
    sample();
    check("p2_rel_pc4", pc_o, 32'h4);
    check("p2_resume_req", imem_req_valid_o, 1'b1);
    check("p2_resume_addr", imem_addr_o, 32'hC);

    // Two requests in flight at latency 3, then redirect to 0x103.
    next_cycle();
    imem_req_ready_i = 1'b0;
    repeat (8) next_cycle();
    lat = 3;
    imem_req_ready_i = 1'b1;
    next_cycle();
    next_cycle();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    sample();
    check("p3_redir_req", imem_req_valid_o, 1'b0);
    next_cycle();
    redirect_i = 1'b0;
    sample();
    check("p3_req_valid", imem_req_valid_o, 1'b1);
    check("p3_addr", imem_addr_o, 32'h100);
    check("p3_valid0", valid_o, 1'b0);
    for (int n = 0; n < 12 && !valid_o; n++) begin
      next_cycle();
      sample();
    end
    check("p3_wait_valid", valid_o, 1'b1);
    check("p3_first_pc", pc_o, 32'h100);
    check("p3_first_instr", instruction_o, 32'h100 ^ KEY);

    // Redirect in a cycle with a response and a pop.
    next_cycle();
    lat = 1;
    repeat (10) next_cycle();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    sample();
    check("p4_pre_valid", valid_o, 1'b1);
    check("p4_pre_rsp", imem_rsp_valid_i, 1'b1);
    next_cycle();
    redirect_i = 1'b0;
    sample();
    check("p4_valid0", valid_o, 1'b0);
    check("p4_addr", imem_addr_o, 32'h200);
    for (int n = 0; n < 12 && !valid_o; n++) begin
      next_cycle();
      sample();
    end
    check("p4_wait_valid", valid_o, 1'b1);
    check("p4_first_pc", pc_o, 32'h200);

    // Back-to-back redirects: the second one wins.
    next_cycle();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0300;
    next_cycle();
    redirect_pc_i = 32'h0000_0405;
    next_cycle();
    redirect_i = 1'b0;
    sample();
    check("p5_valid0", valid_o, 1'b0);
    check("p5_addr", imem_addr_o, 32'h404);
    for (int n = 0; n < 12 && !valid_o; n++) begin
      next_cycle();
      sample();
    end
    check("p5_wait_valid", valid_o, 1'b1);
    check("p5_first_pc", pc_o, 32'h404);
    check("p5_first_instr", instruction_o, 32'h404 ^ KEY);

    repeat (5) next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset; bits [1:0] SHALL be 0.
REQ-002 Parameter DEPTH, default 2: instruction buffer entries, and also the cap on in-flight requests; legal values 2..8.
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 imem_req_valid_o  output  1  fetch request is valid.
REQ-006 imem_req_ready_i  input  1  memory accepts the request.
REQ-007 imem_addr_o  output  32  word-aligned fetch address.
REQ-008 imem_rsp_valid_i  input  1  response data is valid; responses return in order, at least 1 cycle after acceptance.
REQ-009 imem_rsp_data_i  input  32  fetched instruction word.
REQ-010 redirect_i  input  1  control-flow change: flush, then restart at redirect_pc_i.
REQ-011 redirect_pc_i  input  32  new fetch address; bits [1:0] SHALL be ignored and treated as 0.
REQ-012 valid_o  output  1  instruction_o and pc_o are valid toward decode.
REQ-013 ready_i  input  1  decode consumes the current instruction.
REQ-014 instruction_o  output  32  instruction word at the buffer head.
REQ-015 pc_o  output  32  address of instruction_o.

Function
REQ-016 A request SHALL be accepted only in a cycle where imem_req_valid_o && imem_req_ready_i.
- On acceptance, fetch_pc SHALL advance by 4, wrapping modulo 2^32.
REQ-017 imem_req_valid_o SHALL be 1 iff all hold:
- (buffer count + inflight) < DEPTH;
- redirect_i = 0.
REQ-018 imem_addr_o SHALL equal fetch_pc, and SHALL hold stable while imem_req_valid_o=1 and imem_req_ready_i=0.
REQ-019 Each accepted request SHALL push its address into an in-order PC queue.
- On each kept response, that address pairs with imem_rsp_data_i as one buffer entry.
REQ-020 inflight SHALL count requests accepted but not yet responded to.
- Accept and response in the same cycle: inflight SHALL stay unchanged.
REQ-021 drop SHALL count stale responses still owed.
- Any imem_rsp_valid_i while drop>0 SHALL decrement drop and SHALL NOT write the buffer.
REQ-022 The buffer SHALL be a DEPTH-entry FIFO.
- valid_o = (count != 0).
- Pop SHALL occur when valid_o && ready_i.
- A push and a pop in the same cycle SHALL leave count unchanged.
REQ-023 A response into an empty buffer SHALL raise valid_o in the next cycle (1-cycle response-to-decode latency); there is no combinational bypass.
REQ-024 The buffer SHALL never overflow; this is guaranteed by REQ-017, and the bench SHALL assert it.
REQ-025 When redirect_i=1, the next-edge state SHALL be:
- fetch_pc = {redirect_pc_i[31:2],2'b00};
- buffer count = 0 and PC queue empty;
- drop = drop + inflight, excluding any response arriving that same cycle;
- inflight = 0.
REQ-026 A response arriving in the redirect cycle SHALL be discarded.
REQ-027 A pop in the redirect cycle SHALL complete as seen by decode.
- valid_o SHALL be 0 in the cycle after a redirect.
REQ-028 New requests SHALL resume the cycle after a redirect, even while drop>0.
- In-order return guarantees that stale responses precede new ones.
REQ-029 Back-to-back redirects SHALL each apply REQ-025; the last one determines fetch_pc.
REQ-030 valid_o, instruction_o and pc_o SHALL hold stable while valid_o=1 and ready_i=0.

Reset
REQ-031 On rst_ni=0, asynchronously:
- fetch_pc = RESET_PC;
- count = inflight = drop = 0;
- valid_o = 0, imem_req_valid_o = 0;
- instruction_o = 32'h0000_0013 (NOP), pc_o = RESET_PC.
REQ-032 The first request SHALL issue in the first cycle after rst_ni deasserts, with imem_addr_o = RESET_PC.
REQ-033 Reset asserted mid-operation SHALL abandon in-flight requests without draining them; the memory model is reset alongside this block.

Verification
REQ-034 Reset release, with memory always ready and 1-cycle latency, ready_i=1:
- expect addresses 0,4,8,... on consecutive cycles;
- expect valid_o from cycle 2 onward, with pc_o=0 then 4, 8.
REQ-035 ready_i held 0 for 10 cycles:
- expect exactly DEPTH requests issued;
- then imem_req_valid_o=0, valid_o=1, pc_o=0 stable;
- on release, expect pcs 0,4 in order and fetch resumes.
REQ-036 With 2 requests in flight (memory latency 3), redirect_i=1, redirect_pc_i=32'h0000_0103:
- both stale responses are dropped;
- next request imem_addr_o=32'h0000_0100;
- first valid pc_o=32'h100.
REQ-037 Redirect in the same cycle as a response and a pop:
- the popped entry is delivered;
- the response is dropped;
- valid_o=0 in the next cycle.
REQ-038 Wrap-around from RESET_PC=32'hFFFF_FFF8:
- expect addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 rst_ni pulsed low mid-stream with a non-empty buffer:
- valid_o=0 immediately (asynchronous);
- after release, the first request is at RESET_PC.
